pipe_regalu: RTL and testbench
==============================

// Module: pipe_regalu
// PURPOSE
//  Three-stage pipelined execute datapath: X (ALU), M (data memory), W (writeback).
//  Contains the register file, ALU, operand/result muxes and data memory.
//  Adds operand forwarding, a one-cycle load-use stall and a valid/ready issue interface.
//  Sits between the decoder/control unit and the PC/branch logic; eq feeds branch resolution.
// PARAMETERS
//  DATA_WIDTH     32   datapath and register width
//  ADDRESS_WIDTH  5    register index width; file holds 2**ADDRESS_WIDTH regs
//  MEM_DEPTH      256  data memory depth in DATA_WIDTH words (power of 2)
// PORTS
//  clk        in   1                single clock, all state on rising edge
//  rst        in   1                asynchronous, active-high reset
//  in_valid   in   1                issue slot carries an instruction
//  in_ready   out  1                0 = load-use stall; instruction must be held
//  rs1        in   ADDRESS_WIDTH    source register 1
//  rs2        in   ADDRESS_WIDTH    source register 2 / store data source
//  rd         in   ADDRESS_WIDTH    destination register
//  RegWrite   in   1                write rd at W
//  ALUsrc     in   1                ALU op2: 0 = rs2 value, 1 = ImmOp
//  ResultSrc  in   1                W result: 0 = ALU out, 1 = memory read data
//  MemWrite   in   1                store rs2 value to mem[ALU out] in M
//  ALUCtrl    in   3                ALU operation (encoding below)
//  ImmOp      in   DATA_WIDTH       immediate operand
//  eq         out  1                forwarded op1 == op2 for instruction in X; 0 if X empty
//  wb_valid   out  1                an instruction is retiring in W this cycle
//  a0         out  DATA_WIDTH       committed value of register 10
// BEHAVIOUR
//  Reset: pipeline valids X/M/W cleared, all registers cleared to 0; in_ready=1,
//   eq=0, wb_valid=0, a0=0. Data memory contents are not reset.
//  Issue: accepted on in_valid & in_ready. Register read in issue cycle, write-first:
//   a same-cycle W write to the read index is bypassed into the read value.
//  Latency: accept cycle 0 -> X cycle 1 -> M cycle 2 -> W cycle 3; register written on
//   cycle-3 edge; a0 reflects it from cycle 4. Throughput 1 instr/cycle without stalls.
//  Forwarding into X (priority M over W over captured value), per operand:
//   M valid & RegWrite & !ResultSrc & rd!=0 & rd==src -> M ALU result;
//   else W valid & RegWrite & rd!=0 & rd==src -> W result. Store data forwarded likewise.
//  Load-use stall: in_ready = !(X valid & X.ResultSrc & X.RegWrite & X.rd!=0 &
//   (rs1==X.rd | rs2==X.rd)); rs2 always compared (conservative). On stall a bubble
//   enters X; X/M/W keep advancing. in_valid=0 also inserts a bubble.
//  Register 0 reads as 0 always; writes to it are discarded.
//  ALUCtrl: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt signed (result 0/1),
//   110 sll, 111 srl; shift amount = op2[$clog2(DATA_WIDTH)-1:0]. Arithmetic mod 2**DATA_WIDTH.
//  Memory: byte address ALU out, word index = addr[$clog2(MEM_DEPTH)+1:2]; higher bits
//   ignored (wrap), low 2 bits ignored. Store written on M-cycle edge. Load read is
//   registered on M->W edge; a load directly after a store to same word returns new data.
//  Simultaneous store in M and load of same word in M impossible (one instr per stage).
//  Reset mid-operation: all in-flight instructions discarded, none retire.
// TESTING
//  Reset then no issue -> a0=0, wb_valid=0, in_ready=1, eq=0.
//  addi x10,x0,5 ; add x10,x10,x10 back-to-back -> M forward, a0=10 at cycle 5, no stall.
//  sw x10(=10),4(x0) ; lw x11,4(x0) ; add x10,x11,x11 -> in_ready=0 exactly 1 cycle on add; a0=20.
//  Write x0 with 7 then add x10,x0,x0 -> a0=0.
//  sub with op1=3, op2=5 -> 0xFFFFFFFE; slt -1,1 -> 1; srl 0x80000000 by 31 -> 1; eq=1 on 4,4.
//  Assert rst while 3 instrs in flight -> wb_valid stays 0, a0 returns to 0 asynchronously.

Source files
------------

// File: rtl/pipe_regalu.sv
`default_nettype none
// ============================================================================
// Module      : pipe_regalu
// Description : Three-stage execute datapath (X = ALU, M = data memory,
//               W = writeback) with register file, operand forwarding,
//               one-cycle load-use stall and a valid/ready issue slot.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_regalu #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int MEM_DEPTH     = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDRESS_WIDTH-1:0] rs1,
  input  logic [ADDRESS_WIDTH-1:0] rs2,
  input  logic [ADDRESS_WIDTH-1:0] rd,
  input  logic                     RegWrite,
  input  logic                     ALUsrc,
  input  logic                     ResultSrc,
  input  logic                     MemWrite,
  input  logic [2:0]               ALUCtrl,
  input  logic [DATA_WIDTH-1:0]    ImmOp,
  output logic                     eq,
  output logic                     wb_valid,
  output logic [DATA_WIDTH-1:0]    a0
);

  localparam int NREGS  = 2 ** ADDRESS_WIDTH;
  localparam int SHW    = $clog2(DATA_WIDTH);
  localparam int MIW    = $clog2(MEM_DEPTH);
  localparam int A0_IDX = 10;

  // Architectural state
  logic [DATA_WIDTH-1:0] regs_q [NREGS];
  logic [DATA_WIDTH-1:0] mem_q  [MEM_DEPTH];

  // X stage
  logic                     x_valid_q;
  logic [ADDRESS_WIDTH-1:0] x_rs1_q, x_rs2_q, x_rd_q;
  logic                     x_regwrite_q, x_alusrc_q, x_resultsrc_q, x_memwrite_q;
  logic [2:0]               x_aluctrl_q;
  logic [DATA_WIDTH-1:0]    x_imm_q, x_rv1_q, x_rv2_q;

  // M stage
  logic                     m_valid_q;
  logic [ADDRESS_WIDTH-1:0] m_rd_q;
  logic                     m_regwrite_q, m_resultsrc_q, m_memwrite_q;
  logic [DATA_WIDTH-1:0]    m_alu_q, m_sdata_q;

  // W stage
  logic                     w_valid_q;
  logic [ADDRESS_WIDTH-1:0] w_rd_q;
  logic                     w_regwrite_q, w_resultsrc_q;
  logic [DATA_WIDTH-1:0]    w_alu_q, mem_rdata_q;

  // Combinational helpers
  logic                     issue;
  logic                     w_we;
  logic [DATA_WIDTH-1:0]    w_result;
  logic [DATA_WIDTH-1:0]    rd1_val, rd2_val;
  logic                     m_fwd_ok;
  logic [DATA_WIDTH-1:0]    op1, fwd2, op2;
  logic [DATA_WIDTH-1:0]    x_alu_d;
  logic [MIW-1:0]           m_idx;

  // Writeback result and its commit enable; rd 0 never commits, so regs_q[0] stays 0
  assign w_result = w_resultsrc_q ? mem_rdata_q : w_alu_q;
  assign w_we     = w_valid_q & w_regwrite_q & (w_rd_q != '0);

  // A load in X whose destination is read by the issuing instruction cannot be
  // forwarded in time; rs2 is compared even when the instruction uses ImmOp.
  assign in_ready = ~(x_valid_q & x_resultsrc_q & x_regwrite_q & (x_rd_q != '0) &
                      ((rs1 == x_rd_q) | (rs2 == x_rd_q)));
  assign issue    = in_valid & in_ready;

  // Register read in the issue cycle, write-first against the retiring instruction
  always_comb begin
    rd1_val = regs_q[rs1];
    rd2_val = regs_q[rs2];
    if (w_we && (w_rd_q == rs1)) rd1_val = w_result;
    if (w_we && (w_rd_q == rs2)) rd2_val = w_result;
  end

  // Operand forwarding into X: M ALU result first, then W result, then captured value
  assign m_fwd_ok = m_valid_q & m_regwrite_q & ~m_resultsrc_q & (m_rd_q != '0);

  always_comb begin
    op1 = x_rv1_q;
    if (m_fwd_ok && (m_rd_q == x_rs1_q))  op1 = m_alu_q;
    else if (w_we && (w_rd_q == x_rs1_q)) op1 = w_result;
    fwd2 = x_rv2_q;
    if (m_fwd_ok && (m_rd_q == x_rs2_q))  fwd2 = m_alu_q;
    else if (w_we && (w_rd_q == x_rs2_q)) fwd2 = w_result;
  end

  assign op2 = x_alusrc_q ? x_imm_q : fwd2;
  assign eq  = x_valid_q & (op1 == op2);

  // ALU
  always_comb begin
    x_alu_d = '0;
    case (x_aluctrl_q)
      3'b000:  x_alu_d = op1 + op2;
      3'b001:  x_alu_d = op1 - op2;
      3'b010:  x_alu_d = op1 & op2;
      3'b011:  x_alu_d = op1 | op2;
      3'b100:  x_alu_d = op1 ^ op2;
      3'b101:  x_alu_d = {{(DATA_WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
      3'b110:  x_alu_d = op1 << op2[SHW-1:0];
      3'b111:  x_alu_d = op1 >> op2[SHW-1:0];
      default: x_alu_d = '0;
    endcase
  end

  // Word index: byte-offset bits dropped, address bits above the depth wrap
  assign m_idx = m_alu_q[MIW+1:2];

  // Issue -> X capture; a stall or empty slot enters X as a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_valid_q     <= 1'b0;
      x_rs1_q       <= '0;
      x_rs2_q       <= '0;
      x_rd_q        <= '0;
      x_regwrite_q  <= 1'b0;
      x_alusrc_q    <= 1'b0;
      x_resultsrc_q <= 1'b0;
      x_memwrite_q  <= 1'b0;
      x_aluctrl_q   <= '0;
      x_imm_q       <= '0;
      x_rv1_q       <= '0;
      x_rv2_q       <= '0;
    end else begin
      x_valid_q     <= issue;
      x_rs1_q       <= rs1;
      x_rs2_q       <= rs2;
      x_rd_q        <= rd;
      x_regwrite_q  <= RegWrite;
      x_alusrc_q    <= ALUsrc;
      x_resultsrc_q <= ResultSrc;
      x_memwrite_q  <= MemWrite;
      x_aluctrl_q   <= ALUCtrl;
      x_imm_q       <= ImmOp;
      x_rv1_q       <= rd1_val;
      x_rv2_q       <= rd2_val;
    end
  end

  // X -> M -> W advance unconditionally every cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid_q     <= 1'b0;
      m_rd_q        <= '0;
      m_regwrite_q  <= 1'b0;
      m_resultsrc_q <= 1'b0;
      m_memwrite_q  <= 1'b0;
      m_alu_q       <= '0;
      m_sdata_q     <= '0;
      w_valid_q     <= 1'b0;
      w_rd_q        <= '0;
      w_regwrite_q  <= 1'b0;
      w_resultsrc_q <= 1'b0;
      w_alu_q       <= '0;
    end else begin
      m_valid_q     <= x_valid_q;
      m_rd_q        <= x_rd_q;
      m_regwrite_q  <= x_regwrite_q;
      m_resultsrc_q <= x_resultsrc_q;
      m_memwrite_q  <= x_memwrite_q;
      m_alu_q       <= x_alu_d;
      m_sdata_q     <= fwd2;
      w_valid_q     <= m_valid_q;
      w_rd_q        <= m_rd_q;
      w_regwrite_q  <= m_regwrite_q;
      w_resultsrc_q <= m_resultsrc_q;
      w_alu_q       <= m_alu_q;
    end
  end

  // Data memory: store commits on the M edge, load data registered into W (no reset)
  always_ff @(posedge clk) begin
    if (m_valid_q && m_memwrite_q) mem_q[m_idx] <= m_sdata_q;
    mem_rdata_q <= mem_q[m_idx];
  end

  // Register file commit at the end of W
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (w_we) begin
      regs_q[w_rd_q] <= w_result;
    end
  end

  assign wb_valid = w_valid_q;
  assign a0       = regs_q[A0_IDX];

endmodule
`default_nettype wire

// File: tb/tb_pipe_regalu.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_regalu
// Description : Directed and random bench for pipe_regalu. An in-order
//               architectural model executes each accepted instruction at
//               once; its effects are scheduled at the documented latencies.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_regalu;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 256;
  localparam int NC    = 4096;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] rs1, rs2, rd;
  logic          RegWrite, ALUsrc, ResultSrc, MemWrite;
  logic [2:0]    ALUCtrl;
  logic [DW-1:0] ImmOp;
  logic          eq;
  logic          wb_valid;
  logic [DW-1:0] a0;

  pipe_regalu #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rs1(rs1), .rs2(rs2), .rd(rd), .RegWrite(RegWrite), .ALUsrc(ALUsrc),
    .ResultSrc(ResultSrc), .MemWrite(MemWrite), .ALUCtrl(ALUCtrl), .ImmOp(ImmOp),
    .eq(eq), .wb_valid(wb_valid), .a0(a0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural model and per-cycle expectations
  logic [DW-1:0] R [32];
  logic [DW-1:0] M [DEPTH];
  bit            exp_wb [NC];
  bit            exp_eq [NC];
  bit            a0_set [NC];
  logic [DW-1:0] a0_val [NC];
  int            cyc;
  logic [DW-1:0] cur_a0;
  bit            xv, xld;
  logic [AW-1:0] xrd;
  bit            last_acc;
  int            stall_obs;
  bit            eq_seen;
  int            n_cmp, n_bad;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  function automatic logic [DW-1:0] ref_alu(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6:    return a << (b % 32);
      default: return a >> (b % 32);
    endcase
  endfunction

  // One cycle: drive inputs at negedge, check outputs, run the model on acceptance
  task automatic step(input bit v, input logic [AW-1:0] a, input logic [AW-1:0] b,
                      input logic [AW-1:0] d, input bit rw, input bit asrc, input bit rsrc,
                      input bit mw, input logic [2:0] op, input logic [DW-1:0] imm);
    bit            ready_exp;
    logic [DW-1:0] v1, v2, o2, res, wv;
    int            idx;
    @(negedge clk);
    in_valid = v; rs1 = a; rs2 = b; rd = d; RegWrite = rw; ALUsrc = asrc;
    ResultSrc = rsrc; MemWrite = mw; ALUCtrl = op; ImmOp = imm;
    #1;
    if (a0_set[cyc]) cur_a0 = a0_val[cyc];
    ready_exp = !(xv && xld && ((a == xrd) || (b == xrd)));
    check("in_ready", {31'b0, in_ready}, {31'b0, ready_exp});
    check("eq",       {31'b0, eq},       {31'b0, exp_eq[cyc]});
    check("wb_valid", {31'b0, wb_valid}, {31'b0, exp_wb[cyc]});
    check("a0",       a0,                cur_a0);
    if (in_ready === 1'b0) stall_obs++;
    if (eq === 1'b1) eq_seen = 1'b1;
    last_acc = v && ready_exp;
    if (last_acc) begin
      v1  = R[a];
      v2  = R[b];
      o2  = asrc ? imm : v2;
      res = ref_alu(op, v1, o2);
      idx = int'((res >> 2) % DEPTH);
      if (mw) M[idx] = v2;
      wv  = rsrc ? M[idx] : res;
      if (rw && d != 0) R[d] = wv;
      exp_eq[cyc+1] = (v1 == o2);
      exp_wb[cyc+3] = 1'b1;
      a0_set[cyc+4] = 1'b1;
      a0_val[cyc+4] = R[10];
    end
    xv  = last_acc;
    xld = last_acc && rsrc && rw && (d != 0);
    xrd = d;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 32'd0);
  endtask

  // Present an instruction and hold it until accepted (bounded)
  task automatic issue(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] d,
                       input bit rw, input bit asrc, input bit rsrc, input bit mw,
                       input logic [2:0] op, input logic [DW-1:0] imm);
    for (int t = 0; t < 3; t++) begin
      step(1, a, b, d, rw, asrc, rsrc, mw, op, imm);
      if (last_acc) break;
    end
  endtask

  task automatic addi(input logic [AW-1:0] d, input logic [DW-1:0] imm);
    issue(0, 0, d, 1, 1, 0, 0, 3'd0, imm);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) R[i] = '0;
    for (int k = cyc; k < NC; k++) begin
      exp_wb[k] = 1'b0; exp_eq[k] = 1'b0; a0_set[k] = 1'b0;
    end
    cur_a0 = '0;
    xv = 1'b0; xld = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit            v, rw, asrc, rsrc, mw, held;
    logic [AW-1:0] a, b, d;
    logic [2:0]    op;
    logic [DW-1:0] imm;
    int            kind, w;

    n_cmp = 0; n_bad = 0; cyc = 0; stall_obs = 0; eq_seen = 0; last_acc = 0;
    for (int k = 0; k < NC; k++) begin
      exp_wb[k] = 0; exp_eq[k] = 0; a0_set[k] = 0; a0_val[k] = '0;
    end
    for (int i = 0; i < DEPTH; i++) M[i] = '0;
    model_reset();
    in_valid = 0; rs1 = 0; rs2 = 0; rd = 0; RegWrite = 0; ALUsrc = 0;
    ResultSrc = 0; MemWrite = 0; ALUCtrl = 0; ImmOp = 0;

    // Reset values while reset is held
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_a0",       a0,                32'd0);
    check("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_eq",       {31'b0, eq},       32'd0);
    rst = 1'b0;

    // Reset then no issue
    idle(4);

    // Back-to-back dependent adds through the M forward, no stall
    stall_obs = 0;
    addi(10, 32'd5);
    issue(10, 10, 10, 1, 0, 0, 0, 3'd0, 32'd0);
    idle(6);
    check("fwd_a0",    a0, 32'd10);
    check("fwd_stall", stall_obs, 32'd0);

    // Store, load, dependent add: exactly one stall cycle
    stall_obs = 0;
    issue(0, 10, 0, 0, 1, 0, 1, 3'd0, 32'd4);
    issue(0, 0, 11, 1, 1, 1, 0, 3'd0, 32'd4);
    issue(11, 11, 10, 1, 0, 0, 0, 3'd0, 32'd0);
    idle(6);
    check("ldu_a0",    a0, 32'd20);
    check("ldu_stall", stall_obs, 32'd1);

    // Writes to x0 are discarded
    addi(0, 32'd7);
    issue(0, 0, 10, 1, 0, 0, 0, 3'd0, 32'd0);
    idle(6);
    check("x0_a0", a0, 32'd0);

    // ALU corner cases
    addi(1, 32'hFFFF_FFFF);
    issue(1, 0, 10, 1, 1, 0, 0, 3'd5, 32'd1);
    idle(6);
    check("slt_a0", a0, 32'd1);
    addi(1, 32'd3);
    addi(2, 32'd5);
    issue(1, 2, 10, 1, 0, 0, 0, 3'd1, 32'd0);
    idle(6);
    check("sub_a0", a0, 32'hFFFF_FFFE);
    addi(1, 32'h8000_0000);
    issue(1, 0, 10, 1, 1, 0, 0, 3'd7, 32'd31);
    idle(6);
    check("srl_a0", a0, 32'd1);
    eq_seen = 0;
    addi(1, 32'd4);
    issue(1, 0, 10, 1, 1, 0, 0, 3'd0, 32'd4);
    idle(6);
    check("eq_seen", {31'b0, eq_seen}, 32'd1);
    check("eq_a0",   a0, 32'd8);

    // Initialise eight memory words (high/low address bits randomised to exercise wrap)
    for (int k = 0; k < 8; k++) begin
      addi(1, $urandom);
      issue(0, 1, 0, 0, 1, 0, 1, 3'd0, ($urandom & 32'hFFFF_FC00) | (k << 2) | ($urandom & 3));
    end
    idle(4);

    // Random instruction stream
    held = 0;
    v = 0; a = 0; b = 0; d = 0; rw = 0; asrc = 0; rsrc = 0; mw = 0; op = 0; imm = 0;
    for (int k = 0; k < 500; k++) begin
      if (!held) begin
        v    = ($urandom % 10) < 8;
        kind = $urandom % 10;
        a    = AW'($urandom % 12);
        b    = AW'($urandom % 12);
        d    = AW'($urandom % 12);
        w    = $urandom % 8;
        if (kind < 2) begin
          a = 0; rw = 1; asrc = 1; rsrc = 1; mw = 0; op = 3'd0;
          imm = ($urandom & 32'hFFFF_FC00) | (w << 2) | ($urandom & 3);
        end else if (kind == 2) begin
          a = 0; rw = 0; asrc = 1; rsrc = 0; mw = 1; op = 3'd0;
          imm = ($urandom & 32'hFFFF_FC00) | (w << 2) | ($urandom & 3);
        end else begin
          rw = ($urandom % 4) != 0; asrc = $urandom % 2; rsrc = 0; mw = 0;
          op = 3'($urandom % 8);
          imm = ($urandom % 2) ? 32'($urandom % 64) : $urandom;
        end
      end
      step(v, a, b, d, rw, asrc, rsrc, mw, op, imm);
      held = v && !last_acc;
    end
    idle(6);

    // Reset while three instructions are in flight
    addi(10, 32'h55);
    idle(5);
    check("pre_rst_a0", a0, 32'h55);
    addi(10, 32'h111);
    addi(10, 32'h222);
    addi(10, 32'h333);
    step(0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 32'd0);
    #1 rst = 1'b1;
    #1;
    check("async_rst_a0",       a0,                32'd0);
    check("async_rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    check("async_rst_in_ready", {31'b0, in_ready}, 32'd1);
    model_reset();
    idle(2);
    rst = 1'b0;
    idle(6);
    check("post_rst_a0", a0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
